// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter. Accepts one byte when idle and sends
// start bit, 8 data bits LSB first, and stop bit, each held for PERIOD clocks.
module uart_sender #(
  parameter int unsigned PERIOD = 2584
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       out,
  output logic       ready
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Declaration initialisers give power-up values identical to reset values.
  state_t        state_q = IDLE;
  state_t        state_d;
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q = '0;
  logic [2:0]    idx_d;
  logic [7:0]    shreg_q = '0;
  logic [7:0]    shreg_d;
  logic          out_q = 1'b1;
  logic          out_d;
  logic          ready_q = 1'b1;
  logic          ready_d;
  logic          bit_done;

  assign bit_done = (cnt_q == CNT_LAST);

  // out and ready are computed for the next state and registered, so both
  // change exactly on bit boundaries and ready has no path from valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = 1'b1;
        ready_d = 1'b1;
        if (valid) begin
          state_d = START;
          shreg_d = in;
          out_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            out_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            out_d = shreg_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_uart_sender.sv
// Scoreboard bench for uart_sender: accepted bytes are queued, a line monitor
// checks every frame cycle against the 8N1 waveform and the queued byte.
module tb_uart_sender;

  localparam int P  = 4;
  localparam int PB = 2584;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic       out;
  logic       ready;

  logic       b_reset = 1'b1;
  logic       b_valid = 1'b0;
  logic [7:0] b_in = 8'h00;
  logic       b_out;
  logic       b_ready;

  int nchecks = 0;
  int nerrs = 0;

  uart_sender #(.PERIOD(P)) dut (
    .clk(clk), .reset(reset), .in(in_b), .valid(valid), .out(out), .ready(ready)
  );

  uart_sender #(.PERIOD(PB)) dut_big (
    .clk(clk), .reset(b_reset), .in(b_in), .valid(b_valid), .out(b_out), .ready(b_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard feed: every accept edge queues the byte presented on in.
  logic [7:0] exp_q[$];
  int         starts[$];
  int         cyc = 0;
  logic       rst_q = 1'b1;

  always @(posedge clk) begin
    cyc++;
    rst_q <= reset;
    if (reset === 1'b0 && ready === 1'b1 && valid === 1'b1)
      exp_q.push_back(in_b);
  end

  // Line monitor: frame cycle fc belongs to bit fc/P of the 10-bit frame.
  logic       in_frame = 1'b0;
  int         fc;
  int         ferr;
  int         pos;
  logic       lvl;
  logic [7:0] fexp;
  logic [7:0] dec;
  logic       have_exp;

  always @(negedge clk) begin
    if (rst_q) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (out === 1'b0) begin
          in_frame = 1'b1;
          fc = 0;
          ferr = 0;
          dec = '0;
          have_exp = (exp_q.size() != 0);
          check("frame_expected", have_exp, 1'b1);
          fexp = have_exp ? exp_q[0] : 8'h00;
          starts.push_back(cyc);
        end else begin
          check("idle_state", {out, ready}, 2'b11);
        end
      end
      if (in_frame) begin
        pos = fc / P;
        lvl = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : fexp[pos-1];
        if (out !== lvl || ready !== 1'b0) ferr++;
        if (pos >= 1 && pos <= 8 && (fc % P) == P / 2) dec[pos-1] = out;
        fc++;
        if (fc == 10 * P) begin
          in_frame = 1'b0;
          check("frame_shape_errs", ferr, 0);
          check("frame_byte", dec, fexp);
          if (have_exp) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 1000), 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready("send_ready_wait");
    valid = 1'b1;
    in_b  = b;
    @(negedge clk);
    valid = 1'b0;
    in_b  = 8'($urandom);
  endtask

  task automatic small_tests();
    int good;
    int lowcnt;
    int n;
    int sz;
    logic [7:0] b;
    @(negedge clk);
    check("reset_state", {out, ready}, 2'b11);
    @(negedge clk);
    reset = 1'b0;

    good = 0;
    repeat (100) begin
      @(negedge clk);
      if (out === 1'b1 && ready === 1'b1) good++;
    end
    check("idle_100_cycles", good, 100);

    send(8'h55);
    lowcnt = 0;
    repeat (45) begin
      if (ready === 1'b0) lowcnt++;
      @(negedge clk);
    end
    check("ready_low_cycles", lowcnt, 10 * P);

    // Back-to-back with valid held high.
    wait_ready("b2b_ready_wait");
    sz = starts.size();
    valid = 1'b1;
    in_b  = 8'hA3;
    @(negedge clk);
    in_b = 8'h0F;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_ready", (n < 100), 1'b1);
    @(negedge clk);
    valid = 1'b0;
    repeat (45) @(negedge clk);
    check("b2b_frame_count", starts.size() - sz, 2);
    if (starts.size() - sz == 2) check("b2b_start_gap", starts[sz+1] - starts[sz], 10 * P + 1);

    // Input changes after accept must not affect the frame.
    wait_ready("hold_ready_wait");
    valid = 1'b1;
    in_b  = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    in_b = 8'hFF;
    repeat (45) @(negedge clk);

    // Reset during data bit 3 aborts the frame.
    b = 8'($urandom);
    send(b);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midframe_reset", {out, ready}, 2'b11);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    send(8'h81);
    repeat (45) @(negedge clk);

    // Random bytes with random gaps and junk on in while busy.
    repeat (12) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic big_test();
    int good;
    logic [7:0] d;
    logic l;
    d = 8'h41;
    repeat (2) @(negedge clk);
    check("big_reset_state", {b_out, b_ready}, 2'b11);
    b_reset = 1'b0;
    @(negedge clk);
    b_valid = 1'b1;
    b_in = d;
    @(negedge clk);
    b_valid = 1'b0;
    for (int bitn = 0; bitn < 10; bitn++) begin
      l = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : d[bitn-1];
      good = 0;
      for (int i = 0; i < PB; i++) begin
        if (b_out === l && b_ready === 1'b0) good++;
        @(negedge clk);
      end
      check($sformatf("big_bit%0d_width", bitn), good, PB);
    end
    check("big_after_frame", {b_out, b_ready}, 2'b11);
  endtask

  initial begin
    #1;
    check("powerup_small", {out, ready}, 2'b11);
    check("powerup_big", {b_out, b_ready}, 2'b11);
    fork
      small_tests();
      big_test();
    join
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter: PERIOD, 2584, clock cycles per UART bit; legal range PERIOD >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in  input  8  byte to transmit; sampled only on an accept edge.
REQ-005 Port: valid  input  1  high when `in` holds a byte to send.
REQ-006 Port: out  output  1  serial TX line; idle level 1.
REQ-007 Port: ready  output  1  high while idle and able to accept a byte.

Function
REQ-008 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-009 The block SHALL have states IDLE, START, DATA and STOP; ready SHALL be 1 only in IDLE.
REQ-010 An accept SHALL occur at a rising edge where ready=1 and valid=1; in[7:0] SHALL be latched into an internal shift register at that edge.
REQ-011 In IDLE, an edge with valid=0 SHALL leave the state unchanged, with out=1 and ready=1.
REQ-012 After an accept edge, the state SHALL be START in the next cycle, with out=0 and ready=0.
REQ-013 Each bit (start, each data bit, stop) SHALL drive out for exactly PERIOD consecutive cycles, timed by a cycle counter of width clog2(PERIOD).
REQ-014 The counter SHALL restart at 0 on every bit boundary and SHALL NOT accumulate drift between bits.
REQ-015 In DATA, a 3-bit index 0..7 SHALL select the bit on out; out = latched byte[index].
REQ-016 After index 7 completes, the state SHALL go to STOP with out=1.
REQ-017 After the stop bit's PERIOD cycles, the state SHALL go to IDLE with ready=1.
REQ-018 ready SHALL be low for exactly 10*PERIOD cycles per byte.
REQ-019 Back-to-back bytes with valid held high SHALL start every 10*PERIOD+1 cycles, with out=1 during the single ready cycle between frames.
REQ-020 While not in IDLE, changes on in and valid SHALL be ignored; the transmitted byte SHALL be the value latched at accept.
REQ-021 ready SHALL be a registered output with no combinational path from valid; out SHALL be a registered output.
REQ-022 No byte SHALL be dropped or duplicated: each accept edge SHALL yield exactly one complete frame.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, out=1, ready=1, counter=0 and index=0 in the next cycle.
REQ-024 reset SHALL take priority over an accept on the same edge.
REQ-025 reset in mid-frame SHALL abort the frame; the line SHALL return to 1 and no partial remainder SHALL be sent.
REQ-026 Power-up initial values SHALL equal the reset values.

Verification
REQ-027 PERIOD=4; reset, then valid=1, in=0x55 for one accept edge -> out is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; ready is low for 40 cycles.
REQ-028 PERIOD=4; valid=0 for 100 cycles after reset -> out=1 and ready=1 throughout.
REQ-029 PERIOD=4; valid held at 1, in=0xA3 then 0x0F -> two frames decode to 0xA3 and 0x0F; start edges are 41 cycles apart; exactly one ready cycle between frames.
REQ-030 PERIOD=4; in changed to 0xFF two cycles after accepting 0x00 -> the decoded byte is 0x00.
REQ-031 PERIOD=4; reset asserted during data bit 3 -> next cycle out=1 and ready=1; the next accepted byte (0x81) is sent intact.
REQ-032 PERIOD=2584; one byte 0x41 -> each bit is 2584 cycles wide, measured from the start edge, with zero cumulative error over 10 bits.
